seq_detector: RTL

Parametrised serial pattern detector with a match counter. Successor to the fixed 2-bit-state detector FSM: it watches a one-bit serial stream `X` and compares it against a compile-time pattern of any length N. It supports overlapping and non-overlapping detection modes selectable at run time, honours a bit-valid enable, and keeps a saturating count of matches. It sits behind a serial input source in the p1 datapath and drives a one-cycle match pulse `Z`.

---
 rtl/seq_detector.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector
//  Purpose  : Serial N-bit pattern detector with overlap mode, bit-valid
//             enable and a saturating match counter.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             X,
    input  logic             En,
    input  logic             Overlap,
    output logic             Z,
    output logic [CNT_W-1:0] Count,
    output logic             Sat
);

    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] C_FILL_LAST = FILL_W'(N - 1);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t             state_q;
    logic [FILL_W-1:0]  fill_q;
    logic [N-2:0]       hist_q;
    logic               z_q;
    logic [CNT_W-1:0]   count_q;
    logic               sat_q;

    logic [N-1:0]       hist_d;
    logic [FILL_W-1:0]  fill_d;
    logic               full_d;
    logic               match_d;
    logic [CNT_W-1:0]   count_d;

    // Only the N-1 most recent bits need storing: the incoming bit completes
    // the N-bit comparison window.
    assign hist_d  = {hist_q, X};
    assign full_d  = (state_q == S_ARMED) || (fill_q == C_FILL_LAST);
    assign fill_d  = full_d ? C_FILL_FULL : fill_q + FILL_W'(1);
    assign match_d = full_d && (hist_d == PATTERN);
    assign count_d = (match_d && !(&count_q)) ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            hist_q  <= '0;
            z_q     <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (En) begin
            hist_q  <= hist_d[N-2:0];
            z_q     <= match_d;
            count_q <= count_d;
            sat_q   <= &count_d;
            // A non-overlapping match discards the window and refills from zero.
            if (match_d && !Overlap) begin
                state_q <= S_FILL;
                fill_q  <= '0;
            end else begin
                state_q <= full_d ? S_ARMED : S_FILL;
                fill_q  <= fill_d;
            end
        end else begin
            z_q <= 1'b0;
        end
    end

    assign Z     = z_q;
    assign Count = count_q;
    assign Sat   = sat_q;

endmodule
`default_nettype wire
